hack_cpu: RTL and testbench

16-bit Hack-architecture CPU core. It fetches nothing itself: it executes the instruction word presented on `instruction` and drives the program counter, data-memory address, write data and write strobe. It sits between instruction ROM (addressed by `pc`) and data RAM (addressed by `addressM`). It contains the A register, the D register, the PC and the Hack ALU.

---
 rtl/hack_cpu.sv | 76 +++++++
 tb/tb_hack_cpu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hack_cpu.sv
// Hack-architecture CPU core: A/D registers, program counter and the Hack ALU.
// Executes one instruction per clock from the word presented on `instruction`.
module hack_cpu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inM,
    input  logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] outM,
    output logic             writeM,
    output logic [WIDTH-1:0] addressM,
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] PC_STEP = 1;

    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regD;
    logic [WIDTH-1:0] pcReg;
    logic [WIDTH-1:0] aluX;
    logic [WIDTH-1:0] aluY;
    logic [WIDTH-1:0] aluOut;
    logic [WIDTH-1:0] nextA;
    logic             isC;
    logic             zr;
    logic             ng;
    logic             jumpTaken;

    always_comb begin
        isC = instruction[WIDTH-1];

        aluX = instruction[11] ? '0 : regD;
        if (instruction[10]) aluX = ~aluX;

        aluY = instruction[12] ? inM : regA;
        if (instruction[9]) aluY = '0;
        if (instruction[8]) aluY = ~aluY;

        aluOut = instruction[7] ? (aluX + aluY) : (aluX & aluY);
        if (instruction[6]) aluOut = ~aluOut;

        zr = (aluOut == '0);
        ng = aluOut[WIDTH-1];

        jumpTaken = isC & ((instruction[2] & ng) |
                           (instruction[1] & zr) |
                           (instruction[0] & ~ng & ~zr));

        // Jump target is the value A will hold after this edge.
        if (!isC)
            nextA = {1'b0, instruction[WIDTH-2:0]};
        else if (instruction[5])
            nextA = aluOut;
        else
            nextA = regA;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            regA  <= '0;
            regD  <= '0;
            pcReg <= '0;
        end else begin
            regA <= nextA;
            if (isC && instruction[4]) regD <= aluOut;
            pcReg <= jumpTaken ? nextA : (pcReg + PC_STEP);
        end
    end

    assign outM     = aluOut;
    assign writeM   = reset & isC & instruction[3];
    assign addressM = regA;
    assign pc       = pcReg;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: directed test-plan scenarios plus random
// programs compared against a mnemonic-level Hack reference model.
module tb_hack_cpu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inM = '0;
    logic [15:0] instruction = '0;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] addressM;
    logic [15:0] pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] mA = '0, mD = '0, mPC = '0;
    logic [15:0] nA, nD, nPC, expOut;
    logic        expW, expC;

    logic [5:0] compTable [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
        6'b110000, 6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
        6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011, 6'b000111,
        6'b000000, 6'b010101};

    hack_cpu #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .inM(inM), .instruction(instruction),
        .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc)
    );

    always #5 clock = ~clock;

    // Reference ALU by Hack mnemonic: Y is A or M depending on the a bit.
    function automatic logic [15:0] compVal(input logic a, input logic [5:0] c,
                                            input logic [15:0] d, input logic [15:0] ra,
                                            input logic [15:0] m);
        logic [15:0] y;
        y = a ? m : ra;
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return d;
            6'b110000: return y;
            6'b001101: return ~d;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - d;
            6'b110011: return 16'd0 - y;
            6'b011111: return d + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return d - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return d + y;
            6'b010011: return d - y;
            6'b000111: return y - d;
            6'b000000: return d & y;
            6'b010101: return d | y;
            default:   return 16'h0000;
        endcase
    endfunction

    // Drive inputs and predict this cycle's outputs and next state.
    task automatic present(input logic [15:0] ins, input logic [15:0] m, input logic r);
        logic lt, eq, gt, jmp;
        instruction = ins;
        inM = m;
        reset = r;
        #1;
        expC = ins[15];
        if (!ins[15]) begin
            expOut = 16'h0;
            expW = 1'b0;
            nA = {1'b0, ins[14:0]};
            nD = mD;
            nPC = mPC + 16'd1;
        end else begin
            expOut = compVal(ins[12], ins[11:6], mD, mA, m);
            expW = ins[3];
            nA = ins[5] ? expOut : mA;
            nD = ins[4] ? expOut : mD;
            lt = $signed(expOut) < 0;
            eq = expOut == 16'd0;
            gt = $signed(expOut) > 0;
            jmp = (ins[2] & lt) | (ins[1] & eq) | (ins[0] & gt);
            nPC = jmp ? nA : mPC + 16'd1;
        end
        if (!r) begin
            expW = 1'b0;
            nA = '0;
            nD = '0;
            nPC = '0;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
        mA = nA;
        mD = nD;
        mPC = nPC;
    endtask

    task automatic test_reset();
        present(16'hEA8F, 16'h1234, 1'b0);
        checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL reset_writeM got %h want 0", writeM); end
        advance();
        checks++; if (pc !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", pc); end
        checks++; if (addressM !== 16'h0) begin errors++; $display("FAIL reset_A got %h want 0000", addressM); end
        present(16'hE300, 16'h00FF, 1'b1);
        checks++; if (outM !== 16'h0) begin errors++; $display("FAIL reset_D got %h want 0000", outM); end
        present(16'hFC00, 16'h00FF, 1'b1);
        checks++; if (outM !== 16'h00FF || writeM !== 1'b0) begin errors++; $display("FAIL nojump_comb got %h/%b want 00ff/0", outM, writeM); end
        advance();
        checks++; if (pc !== 16'h1) begin errors++; $display("FAIL nojump_pc got %h want 0001", pc); end
    endtask

    task automatic test_jgt();
        logic [15:0] vals [3] = '{16'd7, 16'd0, 16'h8000};
        logic [15:0] pcs [3] = '{16'd7, 16'd8, 16'd9};
        for (int i = 0; i < 3; i++) begin
            present(16'hFC21, vals[i], 1'b1);
            advance();
            checks++; if (pc !== pcs[i]) begin errors++; $display("FAIL jgt_pc[%0d] got %h want %h", i, pc, pcs[i]); end
            checks++; if (addressM !== vals[i]) begin errors++; $display("FAIL jgt_A[%0d] got %h want %h", i, addressM, vals[i]); end
        end
    endtask

    task automatic test_jump_sweep();
        logic [15:0] vals [3] = '{16'd1, 16'd0, 16'h8000};
        logic [15:0] pcs [18] = '{16'd10, 16'd0, 16'd1, 16'd1, 16'd0, 16'd1,
            16'd2, 16'd3, 16'h8000, 16'd1, 16'd2, 16'h8000,
            16'h8001, 16'd0, 16'h8000, 16'd1, 16'd0, 16'h8000};
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 3; i++) begin
                present(16'hFC22 + 16'(j), vals[i], 1'b1);
                advance();
                checks++;
                if (pc !== pcs[j*3+i] || pc !== mPC) begin
                    errors++;
                    $display("FAIL jsweep_pc[%0d,%0d] got %h want %h", j, i, pc, pcs[j*3+i]);
                end
            end
        end
    endtask

    task automatic test_alu_dest();
        present(16'hEAB8, 16'h5555, 1'b1);
        checks++; if (outM !== 16'h0 || writeM !== 1'b1) begin errors++; $display("FAIL adm0 got %h/%b want 0000/1", outM, writeM); end
        advance();
        checks++; if (addressM !== 16'h0) begin errors++; $display("FAIL adm0_A got %h want 0000", addressM); end
        present(16'h0005, 16'h0, 1'b1); advance();
        present(16'hEC10, 16'h0, 1'b1); advance();
        present(16'hE7D0, 16'h0, 1'b1);
        checks++; if (outM !== 16'd6) begin errors++; $display("FAIL dplus1 got %h want 0006", outM); end
        advance();
        present(16'hE308, 16'h9999, 1'b1);
        checks++; if (outM !== 16'd6 || writeM !== 1'b1 || addressM !== 16'd5) begin
            errors++; $display("FAIL mwrite got %h/%b/%h want 0006/1/0005", outM, writeM, addressM);
        end
        advance();
    endtask

    task automatic test_a_instr();
        present(16'h7FFF, 16'hFFFF, 1'b1);
        checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL ainst_writeM got %b want 0", writeM); end
        advance();
        checks++; if (addressM !== 16'h7FFF || pc !== mPC) begin errors++; $display("FAIL ainst got A=%h pc=%h want 7fff/%h", addressM, pc, mPC); end
    endtask

    task automatic test_wrap_reset();
        present(16'hFC27, 16'hFFFF, 1'b1); advance();
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", pc); end
        present(16'hE300, 16'h0, 1'b1); advance();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap got %h want 0000", pc); end
        present(16'hFC27, 16'h0040, 1'b1); advance();
        present(16'hEA8F, 16'h0, 1'b0);
        checks++; if (writeM !== 1'b0) begin errors++; $display("FAIL midreset_writeM got %b want 0", writeM); end
        advance();
        checks++; if (pc !== 16'h0 || addressM !== 16'h0) begin errors++; $display("FAIL midreset got pc=%h A=%h want 0/0", pc, addressM); end
        present(16'h0123, 16'h0, 1'b1); advance();
        checks++; if (pc !== 16'h1 || addressM !== 16'h0123) begin errors++; $display("FAIL resume got pc=%h A=%h want 0001/0123", pc, addressM); end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [15:0] m;
        logic        r;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(1, 0) == 0)
                ins = {1'b0, 15'($urandom)};
            else
                ins = {3'b111, 1'($urandom), compTable[$urandom_range(17, 0)], 6'($urandom)};
            case ($urandom_range(3, 0))
                0: m = 16'h0;
                1: m = 16'h8000;
                default: m = 16'($urandom);
            endcase
            r = ($urandom_range(63, 0) != 0);
            present(ins, m, r);
            checks++;
            if ((expC && outM !== expOut) || writeM !== expW || addressM !== mA) begin
                errors++;
                $display("FAIL rand_comb[%0d] ins=%h got out=%h w=%b A=%h want %h/%b/%h", n, ins, outM, writeM, addressM, expOut, expW, mA);
            end
            advance();
            checks++;
            if (pc !== mPC || addressM !== mA) begin
                errors++;
                $display("FAIL rand_state[%0d] ins=%h got pc=%h A=%h want %h/%h", n, ins, pc, addressM, mPC, mA);
            end
        end
    endtask

    initial begin
        test_reset();
        test_jgt();
        test_jump_sweep();
        test_alu_dest();
        test_a_instr();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
